mem_req_ctrl: RTL

- Initiator/controller for the single-port synchronous RAM block (registered read, 1-cycle read latency, write when write_enable high).
- Accepts client read/write requests on a valid/ready channel and sequences them onto the RAM pins.
- Returns read data on a valid/ready response channel.
- Optionally clears the whole RAM after reset, since the RAM itself has no usable reset-clear.

---
 rtl/mem_req_ctrl_pkg.sv | 15 +
 rtl/mem_init_seq.sv | 29 ++
 rtl/mem_req_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_req_ctrl_pkg.sv
// Shared types and helpers for the mem_req_ctrl RAM initiator.
package mem_req_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RD_WAIT,
    RSP
  } state_t;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_init_seq.sv
// Post-reset clear sweep: steps addresses 0..RAM_DEPTH-1 once, one per cycle, and flags busy.
module mem_init_seq #(
  parameter int ADDR_WIDTH = 10,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  busy
);

  // One extra bit so a full-depth sweep ends at RAM_DEPTH instead of wrapping to 0.
  logic [ADDR_WIDTH:0] count;

  assign step = count < (ADDR_WIDTH + 1)'(RAM_DEPTH);
  assign addr = count[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      busy  <= 1'b0;
    end else begin
      busy <= step;
      if (step) count <= count + (ADDR_WIDTH + 1)'(1);
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Valid/ready request/response front end for a single-port RAM with 1-cycle registered read.
// Define MEM_REQ_CTRL_INIT_EN to clear the whole RAM after every reset.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  req_t   req;
  state_t state;
  logic   req_fire;
  logic   req_in_range;
  logic   rd_launched;
  logic   rd_oob;

  assign req          = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign req_fire     = req_valid && req_ready;
  assign req_in_range = addr_in_range(32'(req.addr), $unsigned(RAM_DEPTH));

`ifdef MEM_REQ_CTRL_INIT_EN
  localparam state_t RESET_STATE = INIT;

  logic                  init_step;
  logic [ADDR_WIDTH-1:0] init_addr;

  mem_init_seq #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_init_seq (
    .clk  (clk),
    .reset(reset),
    .step (init_step),
    .addr (init_addr),
    .busy (busy)
  );
`else
  localparam state_t RESET_STATE = IDLE;

  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= RESET_STATE;
      req_ready        <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
      mem_addr         <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
      rd_launched      <= 1'b0;
      rd_oob           <= 1'b0;
    end else begin
      // NOTE: non-blocking default; a later assignment in this block wins, so the enable is a one-cycle pulse.
      mem_write_enable <= 1'b0;
      case (state)
`ifdef MEM_REQ_CTRL_INIT_EN
        INIT: begin
          if (init_step) begin
            mem_addr         <= init_addr;
            mem_write_data   <= '0;
            mem_write_enable <= 1'b1;
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
`endif
        IDLE: begin
          req_ready <= 1'b1;
          if (req_fire) begin
            mem_addr       <= req.addr;
            mem_write_data <= req.wdata;
            if (req.write) begin
              mem_write_enable <= req_in_range;
            end else begin
              state       <= RD_WAIT;
              req_ready   <= 1'b0;
              rd_oob      <= !req_in_range;
              rd_launched <= 1'b0;
            end
          end
        end
        // First edge lets the RAM register the address; the second captures its output.
        RD_WAIT: begin
          if (!rd_launched) begin
            rd_launched <= 1'b1;
          end else begin
            rsp_rdata <= rd_oob ? '0 : mem_read_data;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

endmodule
